// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - loader state encoding and sizing constants (LOADER_CHECKSUM_EN adds ST_CHK)
package loader_pkg;

   localparam int LOADER_NUM_WORDS = 256;
   localparam int LEN_BYTES        = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_LO = 3'd1,
      ST_LEN_HI = 3'd2,
      ST_DATA   = 3'd3,
`ifdef LOADER_CHECKSUM_EN
      ST_CHK    = 3'd4,
`endif
      ST_DONE   = 3'd5,
      ST_ERR    = 3'd6
   } state_e;

endpackage

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte stream in, instruction-memory write port out
interface program_loader_if #(
   parameter int ADDR_W = 32
);
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport master (
      output in_valid, in_data,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/program_loader_word_packer.sv
// rtl/program_loader_word_packer.sv - little-endian byte-to-word packer
module word_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   input  logic [1:0]  byte_idx,
   output logic [31:0] word,
   output logic        word_valid
);
   logic [23:0] lo_q, lo_d;

   always_comb begin
      lo_d = lo_q;
      if (clear) begin
         lo_d = '0;
      end else if (byte_valid) begin
         case (byte_idx)
            2'd0:    lo_d[7:0]   = byte_data;
            2'd1:    lo_d[15:8]  = byte_data;
            2'd2:    lo_d[23:16] = byte_data;
            default: lo_d        = lo_q;
         endcase
      end
   end

   // The 4th byte is passed straight through so the word is complete on its handshake.
   assign word       = {byte_data, lo_q};
   assign word_valid = byte_valid && (byte_idx == 2'd3);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lo_q <= '0;
      end else begin
         lo_q <= lo_d;
      end
   end
endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream program loader into instruction memory (LOADER_CHECKSUM_EN adds XOR checksum)
module program_loader
   import loader_pkg::*;
#(
   parameter int NUM_WORDS = LOADER_NUM_WORDS,
   parameter int ADDR_W    = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   program_loader_if.slave bus,
   output logic            core_hold,
   output logic            busy,
   output logic            done,
   output logic            error
);
   localparam int CNT_W = $clog2(NUM_WORDS + 1);
   localparam int LEN_W = 8 * LEN_BYTES;

   state_e            state_q, state_d;
   logic [7:0]        len_lo_q, len_lo_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic              imem_we_q, imem_we_d;
   logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
   logic [31:0]       imem_wdata_q, imem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        chk_q, chk_d;
`endif

   logic              in_ready;
   logic              hs;
   logic              data_hs;
   logic              clear;
   logic              last_word;
   logic [LEN_W-1:0]  len_rx;
   logic [31:0]       packed_word;
   logic              word_valid;

   always_comb begin
      in_ready = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) || (state_q == ST_DATA)
`ifdef LOADER_CHECKSUM_EN
                 || (state_q == ST_CHK)
`endif
                 ;
   end

   assign hs        = bus.in_valid && in_ready;
   assign data_hs   = hs && (state_q == ST_DATA);
   assign len_rx    = {bus.in_data, len_lo_q};
   assign last_word = (int'(word_cnt_q) + 1) == int'(len_q);

   word_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .byte_valid (data_hs),
      .byte_data  (bus.in_data),
      .byte_idx   (byte_cnt_q),
      .word       (packed_word),
      .word_valid (word_valid)
   );

   always_comb begin
      state_d      = state_q;
      len_lo_d     = len_lo_q;
      len_d        = len_q;
      word_cnt_d   = word_cnt_q;
      byte_cnt_d   = byte_cnt_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      clear        = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_d        = chk_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               state_d    = ST_LEN_LO;
               word_cnt_d = '0;
               byte_cnt_d = '0;
               clear      = 1'b1;
`ifdef LOADER_CHECKSUM_EN
               chk_d      = '0;
`endif
            end
         end
         ST_LEN_LO: begin
            if (hs) begin
               len_lo_d = bus.in_data;
               state_d  = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            if (hs) begin
               len_d = len_rx;
               if (len_rx == '0) begin
                  state_d = ST_DONE;
               end else if (int'(len_rx) > NUM_WORDS) begin
                  state_d = ST_ERR;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (hs) begin
               byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
               chk_d      = chk_q ^ bus.in_data;
`endif
               // Word count is bounded by len <= NUM_WORDS, so the address never wraps.
               if (word_valid) begin
                  imem_we_d    = 1'b1;
                  imem_addr_d  = ADDR_W'({word_cnt_q, 2'b00});
                  imem_wdata_d = packed_word;
                  word_cnt_d   = word_cnt_q + CNT_W'(1);
                  if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                     state_d = ST_CHK;
`else
                     state_d = ST_DONE;
`endif
                  end
               end
            end
         end
`ifdef LOADER_CHECKSUM_EN
         ST_CHK: begin
            if (hs) begin
               state_d = (bus.in_data == chk_q) ? ST_DONE : ST_ERR;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         len_lo_q     <= '0;
         len_q        <= '0;
         word_cnt_q   <= '0;
         byte_cnt_q   <= '0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
         chk_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         len_lo_q     <= len_lo_d;
         len_q        <= len_d;
         word_cnt_q   <= word_cnt_d;
         byte_cnt_q   <= byte_cnt_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
         chk_q        <= chk_d;
`endif
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.imem_we    = imem_we_q;
   assign bus.imem_addr  = imem_addr_q;
   assign bus.imem_wdata = imem_wdata_q;
   assign busy           = in_ready;
   assign done           = (state_q == ST_DONE);
   assign error          = (state_q == ST_ERR);
   assign core_hold      = (state_q != ST_DONE);
endmodule
